// File: rtl/seq_divider_pkg.sv
// Shared types for the sequential divider: FSM state encoding and iteration counter sizing.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int countWidth(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and try to subtract D.
module div_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_r,
  input  logic [N-1:0] i_q,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_r,
  output logic [N-1:0] o_q
);

  logic [N:0]   w_s;
  logic [N:0]   w_b;
  logic [N-1:0] w_t;
  logic         w_carry;

  assign w_s = {i_r, i_q[N-1]};
  assign w_b = ~{1'b0, i_d};

  // N+1-bit ripple-carry add of S and ~D with carry-in 1; carry-out set means no borrow.
  always_comb begin
    w_carry = 1'b1;
    w_t     = '0;
    for (int i = 0; i < N; i++) begin
      w_t[i]  = w_s[i] ^ w_b[i] ^ w_carry;
      w_carry = (w_s[i] & w_b[i]) | (w_carry & (w_s[i] ^ w_b[i]));
    end
    w_carry = (w_s[N] & w_b[N]) | (w_carry & (w_s[N] ^ w_b[N]));
  end

  // Partial remainder stays below D, so bit N of the kept value is always zero.
  // The no-borrow flag becomes the new quotient bit shifted into Q_next.
  assign o_r = w_carry ? w_t : w_s[N-1:0];
  assign o_q = {i_q[N-2:0], w_carry};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU with sign fix-up on completion.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = countWidth(N);

  state_t        r_state;
  logic [N-1:0]  r_r;
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_d;
  logic [CW-1:0] r_count;
  logic          r_negQ;
  logic          r_negR;

  logic [N-1:0]  w_rNext;
  logic [N-1:0]  w_qNext;
  logic          w_dvdNeg;
  logic          w_dvsNeg;
  logic [N-1:0]  w_dvdMag;
  logic [N-1:0]  w_dvsMag;
  logic          w_overflow;

  assign w_dvdNeg   = is_signed & dividend[N-1];
  assign w_dvsNeg   = is_signed & divisor[N-1];
  assign w_dvdMag   = w_dvdNeg ? -dividend : dividend;
  assign w_dvsMag   = w_dvsNeg ? -divisor : divisor;
  assign w_overflow = is_signed && (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);

  div_step #(.N(N)) u_step (
    .i_r (r_r),
    .i_q (r_q),
    .i_d (r_d),
    .o_r (w_rNext),
    .o_q (w_qNext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_r         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_count     <= '0;
      r_negQ      <= 1'b0;
      r_negR      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        CALC: begin
          r_r     <= w_rNext;
          r_q     <= w_qNext;
          r_count <= r_count - 1'b1;
          if (r_count == CW'(1)) begin
            quotient    <= r_negQ ? -w_qNext : w_qNext;
            remainder   <= r_negR ? -w_rNext : w_rNext;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            r_state     <= DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a launch; results are untouched until completion.
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              r_state     <= DONE;
            end else if (w_overflow) begin
              quotient    <= dividend;
              remainder   <= '0;
              div_by_zero <= 1'b0;
              done        <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_r     <= '0;
              r_q     <= w_dvdMag;
              r_d     <= w_dvsMag;
              r_count <= CW'(N);
              r_negQ  <= w_dvdNeg ^ w_dvsNeg;
              r_negR  <= w_dvdNeg;
              busy    <= 1'b1;
              r_state <= CALC;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider with hand-computed quotients and remainders.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int vectors     = 0;
  int miscompares = 0;

  seq_divider #(.N(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Launch one operation and count edges after the start edge until done is seen.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               output int lat, output int busyCnt);
    @(negedge clk);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    lat     = 0;
    busyCnt = 0;
    while (!done && lat < 100) begin
      if (busy) busyCnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int busyCnt;
    int sawDone;

    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_quot", quotient, 32'd0);
    checkOutput("reset_rem", remainder, 32'd0);
    checkOutput("reset_dbz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] unsigned 100 / 7");
    applyStimulus(1'b0, 32'd100, 32'd7, lat, busyCnt);
    checkOutput("u100_7_lat", 32'(lat), 32'd32);
    checkOutput("u100_7_busy", 32'(busyCnt), 32'd32);
    checkOutput("u100_7_quot", quotient, 32'd14);
    checkOutput("u100_7_rem", remainder, 32'd2);
    checkOutput("u100_7_dbz", {31'b0, div_by_zero}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("u100_7_done_pulse", {31'b0, done}, 32'd0);
    checkOutput("u100_7_hold_quot", quotient, 32'd14);

    $display("[TB] signed -7 / 2 and 7 / -2");
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, lat, busyCnt);
    checkOutput("sm7_2_lat", 32'(lat), 32'd32);
    checkOutput("sm7_2_quot", quotient, 32'hFFFF_FFFD);
    checkOutput("sm7_2_rem", remainder, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, lat, busyCnt);
    checkOutput("s7_m2_quot", quotient, 32'hFFFF_FFFD);
    checkOutput("s7_m2_rem", remainder, 32'd1);

    $display("[TB] divide by zero");
    applyStimulus(1'b0, 32'd5, 32'd0, lat, busyCnt);
    checkOutput("u5_0_lat", 32'(lat), 32'd0);
    checkOutput("u5_0_quot", quotient, 32'hFFFF_FFFF);
    checkOutput("u5_0_rem", remainder, 32'd5);
    checkOutput("u5_0_dbz", {31'b0, div_by_zero}, 32'd1);
    applyStimulus(1'b1, 32'd5, 32'd0, lat, busyCnt);
    checkOutput("s5_0_lat", 32'(lat), 32'd0);
    checkOutput("s5_0_quot", quotient, 32'hFFFF_FFFF);
    checkOutput("s5_0_rem", remainder, 32'd5);
    checkOutput("s5_0_dbz", {31'b0, div_by_zero}, 32'd1);

    $display("[TB] most-negative / -1");
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, busyCnt);
    checkOutput("sovf_lat", 32'(lat), 32'd0);
    checkOutput("sovf_quot", quotient, 32'h8000_0000);
    checkOutput("sovf_rem", remainder, 32'd0);
    checkOutput("sovf_dbz", {31'b0, div_by_zero}, 32'd0);
    applyStimulus(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, busyCnt);
    checkOutput("uovf_lat", 32'(lat), 32'd32);
    checkOutput("uovf_quot", quotient, 32'd0);
    checkOutput("uovf_rem", remainder, 32'h8000_0000);

    $display("[TB] start held during CALC, then back-to-back from DONE");
    @(negedge clk);
    is_signed = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ign_hold_quot", quotient, 32'd0);
    lat = 0;
    while (!done && lat < 100) begin
      dividend  = 32'hDEAD_0000 + 32'(lat);
      divisor   = 32'd3 + 32'(lat);
      is_signed = lat[0];
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("ign_lat", 32'(lat), 32'd32);
    checkOutput("ign_quot", quotient, 32'd14);
    checkOutput("ign_rem", remainder, 32'd2);
    is_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("b2b_busy", {31'b0, busy}, 32'd1);
    checkOutput("b2b_hold_rem", remainder, 32'd2);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("b2b_lat", 32'(lat), 32'd32);
    checkOutput("b2b_quot", quotient, 32'd142);
    checkOutput("b2b_rem", remainder, 32'd6);

    $display("[TB] reset during iteration");
    @(negedge clk);
    is_signed = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_mid_done", {31'b0, done}, 32'd0);
    checkOutput("rst_mid_quot", quotient, 32'd0);
    checkOutput("rst_mid_rem", remainder, 32'd0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    sawDone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) sawDone = 1;
    end
    checkOutput("rst_mid_no_done", 32'(sawDone), 32'd0);
    applyStimulus(1'b0, 32'd9, 32'd3, lat, busyCnt);
    checkOutput("u9_3_lat", 32'(lat), 32'd32);
    checkOutput("u9_3_quot", quotient, 32'd3);
    checkOutput("u9_3_rem", remainder, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle radix-2 restoring integer divider for the M-extension ops DIV, DIVU, REM and REMU.
- It is the subtract-side counterpart of the datapath adder: one N+1-bit subtract per clock, with the carry-out used as the not-borrow flag.
- Sits beside the ALU. The control unit launches it with start/op fields, stalls the PC while busy, and writes back quotient or remainder on done.

Parameters:
- N, 32, operand and result width in bits (N ≥ 2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch request; sampled only when busy=0.
- is_signed  input  1  1 = two's-complement operands (DIV/REM), 0 = unsigned (DIVU/REMU); sampled with start.
- dividend  input  N  numerator; sampled with start.
- divisor  input  N  denominator; sampled with start.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse; results valid in this cycle and held afterwards.
- quotient  output  N  registered quotient.
- remainder  output  N  registered remainder.
- div_by_zero  output  1  registered flag, set with done when divisor was 0.

Behaviour:
- Reset (rst_n=0, takes effect immediately):
  - state=IDLE; busy, done, div_by_zero = 0.
  - quotient, remainder, and the internal R/Q/D/count registers = 0.
  - A reset mid-operation aborts the operation; no done is produced.
- States:
  - IDLE: busy=0, done=0.
  - CALC: busy=1, done=0.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Launch: start=1 at a rising edge while in IDLE or DONE. Back-to-back issue from DONE is legal.
- start while in CALC is ignored, and the inputs are not sampled.
- Special cases, decided at the launch edge: state goes directly to DONE, so done is high in the cycle after the start edge.
  - Divisor = 0: quotient = all ones, remainder = dividend, div_by_zero = 1 (for both signed and unsigned).
  - Signed overflow (is_signed=1, dividend = 2^(N-1) encoding, divisor = all ones): quotient = dividend, remainder = 0, div_by_zero = 0.
- Normal launch: go to CALC.
  - Q is loaded with |dividend| and D with |divisor|; the magnitude is the input itself when unsigned.
  - R (N+1 bits) = 0, count = N.
  - neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend) are latched; both are 0 when unsigned.
- Each CALC edge:
  - S = {R[N-1:0], Q[N-1]}.
  - T = S + ~{0,D} + 1, computed as an N+1-bit add; carry-out 1 means no borrow.
  - If no borrow: R = T, Q = {Q[N-2:0], 1}. Otherwise: R = S, Q = {Q[N-2:0], 0}.
  - count decrements by 1.
- Completion: the edge that performs the iteration with count = 1 also:
  - registers quotient = neg_q ? -Q_next : Q_next;
  - registers remainder = neg_r ? -R_next[N-1:0] : R_next[N-1:0];
  - sets div_by_zero = 0 and moves to DONE.
  - done is therefore high during the Nth cycle after the start edge, for a total of N+1 clocks from start until done drops.
- Result retention: quotient, remainder and div_by_zero hold their values until the next completion or reset. They do not change when a new start is accepted.
- Arithmetic: all negations are two's complement, modulo 2^N. The remainder always takes the dividend's sign, so |remainder| < |divisor|.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the width of count, which is $clog2(N+1).
- One natural sub-module, div_step: a combinational single iteration that takes R, Q and D and produces R_next, Q_next and the borrow bit.
  - Its N+1-bit subtract is built on the team's ripple-carry adder with inverted B and carry-in 1.
- The FSM, operand registers, magnitude/sign logic and output registers stay in seq_divider.

Test Plan:
- Unsigned 100 / 7, is_signed=0 (N=32) → done exactly 32 cycles after the start edge; quotient=14, remainder=2, div_by_zero=0; busy high for 32 cycles.
- Signed -7 / 2 (0xFFFFFFF9 / 0x2) → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Also check 7 / -2 → -3 and 1.
- 5 / 0 in both modes → done one cycle after start; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
- Signed 0x80000000 / 0xFFFFFFFF → done after one cycle; quotient=0x80000000, remainder=0. The same operands unsigned → quotient=0, remainder=0x80000000 after 32 cycles.
- start with new operands asserted every cycle during CALC → ignored, and the first result is unchanged. Then start in the DONE cycle → a second operation completes 32 cycles later with correct values.
- rst_n pulsed low at iteration 10 → busy, done and the outputs go to 0 immediately; no done follows. After release, 9 / 3 gives quotient=3, remainder=0.
